inverse_hadamard4pt_serial: RTL and testbench
=============================================

INVERSE_HADAMARD4PT_SERIAL -- requirements
Module: inverse_hadamard4pt_serial

Interface
REQ-001 SHALL have these parameters: none; widths fixed at 12-bit coefficient in and 9-bit sample out.
REQ-002 SHALL have these ports, clock and reset first:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  y_in carries a coefficient this cycle.
- in_first  input  1  qualified by in_valid; marks coefficient index 0 of a frame.
- y_in  input  12 signed  serial Hadamard coefficient, order n = 0,1,2,3.
- x0, x1, x2, x3  output  9 signed each  reconstructed samples, registered.
- out_valid  output  1  one-cycle pulse when x0..x3 update.
- inexact  output  1  registered with out_valid; the frame's sums were not all multiples of 4.
- sat  output  1  registered with out_valid; at least one sample was clipped.
- frame_err  output  1  one-cycle pulse when a partial frame is abandoned.

Function
REQ-003 SHALL compute x_k = (1/4) * sum over n of H[n][k]*y_n, with H[n][k] = +1 when popcount(n AND k) is even, else -1 (Sylvester order).
- Row signs: n0 ++++, n1 +-+-, n2 ++--, n3 +--+.
REQ-004 SHALL keep a 2-bit index counter idx; each in_valid cycle accepts y_in as coefficient idx, then idx increments modulo 4.
REQ-005 SHALL keep four signed 14-bit accumulators acc0..acc3:
- at idx=0, load acc_k = H[0][k]*y_in (sign-extended);
- otherwise, acc_k = acc_k +/- y_in according to H[idx][k].
REQ-006 SHALL leave idx and the accumulators unchanged in cycles where in_valid=0; gaps of any length are legal.
REQ-007 When the coefficient at idx=3 is accepted, SHALL on the next rising edge register x_k, inexact, sat and out_valid=1. Latency: 1 cycle from the 4th accepted coefficient.
REQ-008 SHALL form x_k as (acc_k + y_in*H[3][k]) arithmetically shifted right by 2 (floor), then saturated to [-256, 255].
REQ-009 SHALL set inexact=1 if any of the four final sums has nonzero bits [1:0]; SHALL set sat=1 if any clip occurred.
REQ-010 SHALL hold x0..x3, inexact and sat between frames; out_valid is high for exactly one cycle per completed frame.
REQ-011 in_first with in_valid at idx=0: normal start, no error.
REQ-012 in_first with in_valid at idx!=0:
- pulse frame_err for 1 cycle;
- discard the partial frame;
- treat y_in as coefficient 0 of a new frame (idx becomes 1).
REQ-013 in_first without in_valid SHALL be ignored.
REQ-014 A new frame's coefficient 0 may arrive in the same cycle out_valid is high; no bubble is required between frames.

Reset
REQ-015 rst=1 SHALL set idx=0, acc0..acc3=0, x0..x3=0, out_valid=0, inexact=0, sat=0, frame_err=0.
REQ-016 rst=1 SHALL take priority over in_valid. Reset mid-frame drops the partial frame with no out_valid and no frame_err.
REQ-017 The first in_valid after rst deasserts SHALL be treated as coefficient 0, whether or not in_first is set.

Structure
REQ-018 A shared package (hadamard_pkg) SHALL hold:
- COEF_W=12, SAMPLE_W=9, ACC_W=14;
- the 4x4 sign table as a constant;
- SAMPLE_MAX=255, SAMPLE_MIN=-256.
REQ-019 SHALL instantiate one sub-module, hadamard_acc_lane, four times (one per k). Each lane holds a single accumulator with load/add/sub control and a shift-saturate output stage. Index counter and framing logic stay in the top level.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Round trip: y = 10, -2, -4, 0 back-to-back, in_first on the first -> one cycle later out_valid=1, x = (1,2,3,4), inexact=0, sat=0.
- Extremes with gaps: y = 1020,0,0,0 with 3 idle cycles between coefficients -> x = (255,255,255,255); then y = -1024,0,0,0 -> x = (-256,-256,-256,-256).
- Saturation: y = 2047,2047,2047,2047 -> x0=255, x1=x2=x3=0, sat=1.
- Inexact: y = 1,0,0,0 -> x = (0,0,0,0), inexact=1.
- Resync: send 5, 6, then in_first with 10, followed by -2, -4, 0 -> frame_err pulses once on the resync cycle; single out_valid with x = (1,2,3,4).
- Reset mid-frame: two coefficients, then rst for 1 cycle -> all outputs 0, no out_valid; the next four coefficients decode as a full frame.

Source files
------------

// File: rtl/hadamard_pkg.sv
// Shared widths, sample limits and Sylvester sign table for the serial
// 4-point inverse Hadamard decoder.
package hadamard_pkg;

  localparam int COEF_W     = 12;
  localparam int SAMPLE_W   = 9;
  localparam int ACC_W      = 14;
  localparam int NUM_LANES  = 4;
  localparam int SAMPLE_MAX = 255;
  localparam int SAMPLE_MIN = -256;

  // H_NEG[n][k] = 1 when H[n][k] = -1, i.e. popcount(n & k) is odd.
  localparam logic [NUM_LANES-1:0][NUM_LANES-1:0] H_NEG = {
    4'b0110,  // n3: + - - +
    4'b1100,  // n2: + + - -
    4'b1010,  // n1: + - + -
    4'b0000   // n0: + + + +
  };

endpackage

// File: rtl/inverse_hadamard4pt_serial_if.sv
// Coefficient-in / sample-out bundle for the serial inverse Hadamard decoder.
interface inverse_hadamard4pt_serial_if;
  import hadamard_pkg::*;

  logic                       in_valid;
  logic                       in_first;
  logic signed [COEF_W-1:0]   y_in;
  logic signed [SAMPLE_W-1:0] x0, x1, x2, x3;
  logic                       out_valid;
  logic                       inexact;
  logic                       sat;
  logic                       frame_err;

  modport master (
    output in_valid, in_first, y_in,
    input  x0, x1, x2, x3, out_valid, inexact, sat, frame_err
  );

  modport slave (
    input  in_valid, in_first, y_in,
    output x0, x1, x2, x3, out_valid, inexact, sat, frame_err
  );

endinterface

// File: rtl/hadamard_acc_lane.sv
// One output lane: signed accumulator with load/add/sub, plus a registered
// floor-divide-by-4 and saturate stage captured on the frame's last term.
module hadamard_acc_lane
  import hadamard_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       acc_en,
  input  logic                       load,
  input  logic                       neg,
  input  logic                       fin,
  input  logic signed [COEF_W-1:0]   y,
  output logic signed [SAMPLE_W-1:0] x,
  output logic                       inexact,
  output logic                       sat
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SAMPLE_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(SAMPLE_MIN);

  logic signed [ACC_W-1:0] acc, yext, term, sum, shifted;

  always_comb begin
    yext    = {{(ACC_W-COEF_W){y[COEF_W-1]}}, y};
    term    = neg ? -yext : yext;
    sum     = (load ? '0 : acc) + term;
    // Arithmetic shift gives floor division, matching the reference rounding.
    shifted = sum >>> 2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      x       <= '0;
      inexact <= 1'b0;
      sat     <= 1'b0;
    end else begin
      if (acc_en) acc <= sum;
      if (fin) begin
        inexact <= |sum[1:0];
        if (shifted > SAT_HI) begin
          x   <= SAT_HI[SAMPLE_W-1:0];
          sat <= 1'b1;
        end else if (shifted < SAT_LO) begin
          x   <= SAT_LO[SAMPLE_W-1:0];
          sat <= 1'b1;
        end else begin
          x   <= shifted[SAMPLE_W-1:0];
          sat <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/inverse_hadamard4pt_serial.sv
// Serial 4-point inverse Hadamard: four coefficients in, four samples out
// one cycle after the last coefficient; index/framing logic lives here.
module inverse_hadamard4pt_serial
  import hadamard_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  inverse_hadamard4pt_serial_if.slave   bus
);

  logic [1:0] idx, eidx;
  logic       accept, load, fin, resync;
  logic       out_valid_q, frame_err_q;

  logic [NUM_LANES-1:0]                    lane_inx, lane_sat;
  logic signed [SAMPLE_W-1:0]              lane_x [NUM_LANES];

  // in_first restarts the frame: the coefficient is always index 0.
  always_comb begin
    accept = bus.in_valid;
    eidx   = (bus.in_valid && bus.in_first) ? 2'd0 : idx;
    resync = accept && bus.in_first && (idx != 2'd0);
    load   = accept && (eidx == 2'd0);
    fin    = accept && (eidx == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= 2'd0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (accept) idx <= eidx + 2'd1;
      out_valid_q <= fin;
      frame_err_q <= resync;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    hadamard_acc_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .acc_en  (accept),
      .load    (load),
      .neg     (H_NEG[eidx][k]),
      .fin     (fin),
      .y       (bus.y_in),
      .x       (lane_x[k]),
      .inexact (lane_inx[k]),
      .sat     (lane_sat[k])
    );
  end

  assign bus.x0        = lane_x[0];
  assign bus.x1        = lane_x[1];
  assign bus.x2        = lane_x[2];
  assign bus.x3        = lane_x[3];
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.inexact   = |lane_inx;
  assign bus.sat       = |lane_sat;

endmodule

// File: tb/tb_inverse_hadamard4pt_serial.sv
// Directed and randomized check of the serial inverse Hadamard decoder
// against a frame-level arithmetic reference model.
module tb_inverse_hadamard4pt_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inverse_hadamard4pt_serial_if bus ();

  inverse_hadamard4pt_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int nvec = 0;
  int nerr = 0;

  // reference state: coefficients of the open frame, expected outputs
  int q[$];
  int e_x[4];
  bit e_ov, e_inx, e_sat, e_ferr;
  int ferr_cnt, ov_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int hsign(input int n, input int k);
    return ($countones(n & k) % 2 == 0) ? 1 : -1;
  endfunction

  task automatic model(input bit r, input bit v, input bit f, input int y);
    int s, xs;
    bit inx, st;
    e_ov   = 0;
    e_ferr = 0;
    if (r) begin
      q.delete();
      foreach (e_x[k]) e_x[k] = 0;
      e_inx = 0;
      e_sat = 0;
    end else if (v) begin
      if (f && q.size() != 0) begin
        e_ferr = 1;
        q.delete();
      end
      q.push_back(y);
      if (q.size() == 4) begin
        inx = 0;
        st  = 0;
        for (int k = 0; k < 4; k++) begin
          s = 0;
          for (int n = 0; n < 4; n++) s += hsign(n, k) * q[n];
          if (s % 4 != 0) inx = 1;
          xs = s >>> 2;
          if (xs > 255)  begin xs = 255;  st = 1; end
          if (xs < -256) begin xs = -256; st = 1; end
          e_x[k] = xs;
        end
        e_inx = inx;
        e_sat = st;
        e_ov  = 1;
        q.delete();
      end
    end
  endtask

  task automatic step(input bit v, input bit f, input int y, input bit r = 0);
    rst          = r;
    bus.in_valid = v;
    bus.in_first = f;
    bus.y_in     = 12'(y);
    @(posedge clk);
    model(r, v, f, y);
    #1;
    chk("out_valid", int'(bus.out_valid), int'(e_ov));
    chk("frame_err", int'(bus.frame_err), int'(e_ferr));
    chk("x0", int'(bus.x0), e_x[0]);
    chk("x1", int'(bus.x1), e_x[1]);
    chk("x2", int'(bus.x2), e_x[2]);
    chk("x3", int'(bus.x3), e_x[3]);
    chk("inexact", int'(bus.inexact), int'(e_inx));
    chk("sat", int'(bus.sat), int'(e_sat));
    ferr_cnt += int'(bus.frame_err);
    ov_cnt   += int'(bus.out_valid);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic expect_x(input string tag, input int a, input int b, input int c, input int d);
    chk({tag, "_x0"}, int'(bus.x0), a);
    chk({tag, "_x1"}, int'(bus.x1), b);
    chk({tag, "_x2"}, int'(bus.x2), c);
    chk({tag, "_x3"}, int'(bus.x3), d);
  endtask

  initial begin
    bus.in_valid = 0;
    bus.in_first = 0;
    bus.y_in     = '0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset_ov", int'(bus.out_valid), 0);
    expect_x("reset", 0, 0, 0, 0);

    // round trip, back-to-back
    step(1, 1, 10); step(1, 0, -2); step(1, 0, -4); step(1, 0, 0);
    chk("rt_ov", int'(bus.out_valid), 1);
    expect_x("rt", 1, 2, 3, 4);
    chk("rt_inexact", int'(bus.inexact), 0);
    chk("rt_sat", int'(bus.sat), 0);
    idle(2);
    chk("rt_hold_ov", int'(bus.out_valid), 0);
    expect_x("rt_hold", 1, 2, 3, 4);

    // extremes with 3-cycle gaps
    step(1, 1, 1020); idle(3); step(1, 0, 0); idle(3);
    step(1, 0, 0); idle(3); step(1, 0, 0);
    expect_x("max", 255, 255, 255, 255);
    chk("max_sat", int'(bus.sat), 0);
    step(1, 1, -1024); idle(3); step(1, 0, 0); idle(3);
    step(1, 0, 0); idle(3); step(1, 0, 0);
    expect_x("min", -256, -256, -256, -256);

    // saturation
    for (int i = 0; i < 4; i++) step(1, i == 0, 2047);
    expect_x("sat", 255, 0, 0, 0);
    chk("sat_flag", int'(bus.sat), 1);

    // inexact, with next frame starting on the out_valid cycle
    step(1, 1, 1); step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    expect_x("inx", 0, 0, 0, 0);
    chk("inx_flag", int'(bus.inexact), 1);

    // resync mid-frame
    ferr_cnt = 0; ov_cnt = 0;
    step(1, 1, 5); step(1, 0, 6); step(1, 1, 10);
    step(1, 0, -2); step(1, 0, -4); step(1, 0, 0);
    idle(1);
    chk("resync_ferr_cnt", ferr_cnt, 1);
    chk("resync_ov_cnt", ov_cnt, 1);
    expect_x("resync", 1, 2, 3, 4);

    // reset mid-frame, then frame without in_first
    ov_cnt = 0;
    step(1, 1, 3); step(1, 0, 4);
    step(0, 0, 0, 1);
    expect_x("rstmid", 0, 0, 0, 0);
    chk("rstmid_ov_cnt", ov_cnt, 0);
    step(1, 0, 10); step(1, 0, -2); step(1, 0, -4); step(1, 0, 0);
    expect_x("postrst", 1, 2, 3, 4);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bit v, f, r;
      v = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(v, f, int'($signed(12'($urandom))), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
